// File: rtl/bullet_scheduler.sv
`timescale 1ns/1ps
// bullet_scheduler
//   Shares NUM_SLOTS bullet slots between two players. Once per frame
//   (frame_tick_i) every slot is advanced, one slot per clock. A single spawn
//   cycle then grants free slots to players whose shoot edge is still pending.
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset
//   frame_tick_i              one-cycle pulse at vblank start
//   player_N_shoot_i          shoot level; the rising edge raises a request
//   player_N_x_i/_y_i         player position, loaded into a slot at spawn
//   bullet_active_o           per-slot valid
//   bullet_x_o/bullet_y_o     slot i at bits [10i+9:10i]
//   bullet_owner_o            0 = player 1, 1 = player 2
//   fire_ack_o                one-cycle grant pulse, bit0 = P1, bit1 = P2
//   busy_o                    FSM outside IDLE
//   frame_overrun_o           sticky: a tick arrived while busy
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | waiting for frame_tick_i
// ST_MOVE  | advancing slot idx_q, one slot per cycle
// ST_SPAWN | granting free slots to pending players
module bullet_scheduler #(
  parameter int NUM_SLOTS    = 4,
  parameter int BULLET_SPEED = 4,
  parameter int SCREEN_W     = 640
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   frame_tick_i,
  input  logic                   player_1_shoot_i,
  input  logic                   player_2_shoot_i,
  input  logic [9:0]             player_1_x_i,
  input  logic [9:0]             player_1_y_i,
  input  logic [9:0]             player_2_x_i,
  input  logic [9:0]             player_2_y_i,
  output logic [NUM_SLOTS-1:0]   bullet_active_o,
  output logic [10*NUM_SLOTS-1:0] bullet_x_o,
  output logic [10*NUM_SLOTS-1:0] bullet_y_o,
  output logic [NUM_SLOTS-1:0]   bullet_owner_o,
  output logic [1:0]             fire_ack_o,
  output logic                   busy_o,
  output logic                   frame_overrun_o
);

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);
  localparam logic [10:0] SPEED_X = 11'(BULLET_SPEED);
  localparam logic [10:0] X_MAX   = 11'(SCREEN_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MOVE  = 2'd1,
    ST_SPAWN = 2'd2
  } state_t;

  state_t           state_q, state_n;
  logic [IDX_W-1:0] idx_q, idx_n;

  logic [NUM_SLOTS-1:0] active_q, owner_q;
  logic [9:0]           x_q [NUM_SLOTS];
  logic [9:0]           y_q [NUM_SLOTS];

  logic shoot_1_q, shoot_2_q, pend_1_q, pend_2_q, prio_q;
  logic edge_1, edge_2;

  assign edge_1 = player_1_shoot_i & ~shoot_1_q;
  assign edge_2 = player_2_shoot_i & ~shoot_2_q;

  always_comb begin
    state_n = state_q;
    idx_n   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_tick_i) begin
          state_n = ST_MOVE;
          idx_n   = '0;
        end
      end
      ST_MOVE: begin
        if (idx_q == LAST_IDX) state_n = ST_SPAWN;
        else                   idx_n   = idx_q + 1'b1;
      end
      ST_SPAWN: begin
        state_n = ST_IDLE;
        idx_n   = '0;
      end
      default: begin
        state_n = ST_IDLE;
        idx_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_n;
      idx_q   <= idx_n;
    end
  end

  // 11-bit move arithmetic: bit 10 of the difference is the borrow, i.e. the
  // bullet would pass the left edge; the sum is range-checked before storing.
  logic [10:0] sum_x, diff_x;
  logic        move_kill;
  logic [9:0]  move_x;

  always_comb begin
    sum_x  = {1'b0, x_q[idx_q]} + SPEED_X;
    diff_x = {1'b0, x_q[idx_q]} - SPEED_X;
    if (owner_q[idx_q]) begin
      move_kill = diff_x[10];
      move_x    = diff_x[9:0];
    end else begin
      move_kill = (sum_x > X_MAX);
      move_x    = sum_x[9:0];
    end
  end

  // lowest and second-lowest inactive slots
  logic [IDX_W-1:0] free_0, free_1;
  logic             has_free_0, has_free_1;

  always_comb begin
    free_0     = '0;
    free_1     = '0;
    has_free_0 = 1'b0;
    has_free_1 = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!active_q[i]) begin
        if (!has_free_0) begin
          free_0     = IDX_W'(i);
          has_free_0 = 1'b1;
        end else if (!has_free_1) begin
          free_1     = IDX_W'(i);
          has_free_1 = 1'b1;
        end
      end
    end
  end

  logic             grant_1, grant_2, prio_flip;
  logic [IDX_W-1:0] slot_1, slot_2;

  always_comb begin
    grant_1   = 1'b0;
    grant_2   = 1'b0;
    slot_1    = free_0;
    slot_2    = free_0;
    prio_flip = 1'b0;
    if (state_q == ST_SPAWN) begin
      if (pend_1_q && pend_2_q) begin
        // contention: the pointer only moves when someone is left waiting
        prio_flip = ~has_free_1;
        if (prio_q) begin
          grant_2 = has_free_0;
          grant_1 = has_free_1;
          slot_1  = free_1;
        end else begin
          grant_1 = has_free_0;
          grant_2 = has_free_1;
          slot_2  = free_1;
        end
      end else begin
        grant_1 = pend_1_q & has_free_0;
        grant_2 = pend_2_q & has_free_0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      active_q        <= '0;
      owner_q         <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
      shoot_1_q       <= 1'b0;
      shoot_2_q       <= 1'b0;
      pend_1_q        <= 1'b0;
      pend_2_q        <= 1'b0;
      prio_q          <= 1'b0;
      fire_ack_o      <= 2'b00;
      busy_o          <= 1'b0;
      frame_overrun_o <= 1'b0;
    end else begin
      shoot_1_q  <= player_1_shoot_i;
      shoot_2_q  <= player_2_shoot_i;
      // a new edge in the grant cycle re-arms the request
      pend_1_q   <= (pend_1_q & ~grant_1) | edge_1;
      pend_2_q   <= (pend_2_q & ~grant_2) | edge_2;
      fire_ack_o <= {grant_2, grant_1};
      busy_o     <= (state_n != ST_IDLE);
      if (frame_tick_i && (state_q != ST_IDLE)) frame_overrun_o <= 1'b1;
      if (prio_flip) prio_q <= ~prio_q;

      if ((state_q == ST_MOVE) && active_q[idx_q]) begin
        if (move_kill) active_q[idx_q] <= 1'b0;
        else           x_q[idx_q]      <= move_x;
      end

      if (grant_1) begin
        active_q[slot_1] <= 1'b1;
        owner_q[slot_1]  <= 1'b0;
        x_q[slot_1]      <= player_1_x_i;
        y_q[slot_1]      <= player_1_y_i;
      end
      if (grant_2) begin
        active_q[slot_2] <= 1'b1;
        owner_q[slot_2]  <= 1'b1;
        x_q[slot_2]      <= player_2_x_i;
        y_q[slot_2]      <= player_2_y_i;
      end
    end
  end

  assign bullet_active_o = active_q;
  assign bullet_owner_o  = owner_q;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
    assign bullet_x_o[10*g +: 10] = x_q[g];
    assign bullet_y_o[10*g +: 10] = y_q[g];
  end

endmodule

// File: tb/tb_bullet_scheduler.sv
`timescale 1ns/1ps
module tb_bullet_scheduler;

  localparam int NS = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        shoot_1 = 1'b0, shoot_2 = 1'b0;
  logic [9:0]  p1x = '0, p1y = '0, p2x = '0, p2y = '0;
  logic [NS-1:0]    bullet_active, bullet_owner;
  logic [10*NS-1:0] bullet_x, bullet_y;
  logic [1:0]  fire_ack;
  logic        busy, frame_overrun;

  bullet_scheduler #(.NUM_SLOTS(NS), .BULLET_SPEED(4), .SCREEN_W(640)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .frame_tick_i     (frame_tick),
    .player_1_shoot_i (shoot_1),
    .player_2_shoot_i (shoot_2),
    .player_1_x_i     (p1x),
    .player_1_y_i     (p1y),
    .player_2_x_i     (p2x),
    .player_2_y_i     (p2y),
    .bullet_active_o  (bullet_active),
    .bullet_x_o       (bullet_x),
    .bullet_y_o       (bullet_y),
    .bullet_owner_o   (bullet_owner),
    .fire_ack_o       (fire_ack),
    .busy_o           (busy),
    .frame_overrun_o  (frame_overrun)
  );

  typedef struct {
    logic [1:0]  ack;
    logic [3:0]  act;
    logic [39:0] x;
    logic [39:0] y;
    logic [3:0]  own;
    logic        ovr;
  } exp_t;

  exp_t exp_q[$];

  int n_vec = 0, n_fail = 0, frame_no = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // hand-maintained expected slot table
  logic [3:0] e_act = '0, e_own = '0;
  logic [9:0] e_x [4];
  logic [9:0] e_y [4];

  task automatic slot(input int i, input logic a, input logic o, input int x, input int y);
    e_act[i] = a;
    e_own[i] = o;
    e_x[i]   = 10'(x);
    e_y[i]   = 10'(y);
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 4; i++) slot(i, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic push(input logic [1:0] ack, input logic ovr);
    exp_t e;
    e.ack = ack;
    e.act = e_act;
    e.own = e_own & e_act;
    e.ovr = ovr;
    e.x   = '0;
    e.y   = '0;
    for (int i = 0; i < 4; i++) begin
      if (e_act[i]) begin
        e.x[10*i +: 10] = e_x[i];
        e.y[10*i +: 10] = e_y[i];
      end
    end
    exp_q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  logic busy_prev = 1'b0;
  int   busy_len = 0;
  bit   pulse_chk = 1'b0;
  bit   mon_hold = 1'b1;

  always @(negedge clk) begin
    if (mon_hold) begin
      busy_prev = busy;
      busy_len  = 0;
      pulse_chk = 1'b0;
    end else begin
      if (pulse_chk) begin
        chk($sformatf("f%0d_ack_pulse", frame_no), 64'(fire_ack), 64'd0);
        pulse_chk = 1'b0;
      end else if (busy_prev && !busy) begin
        frame_no++;
        if (exp_q.size() == 0) begin
          chk($sformatf("f%0d_unexpected_frame", frame_no), 64'd1, 64'd0);
        end else begin
          exp_t e;
          logic [39:0] m;
          e = exp_q.pop_front();
          m = '0;
          for (int i = 0; i < 4; i++) if (e.act[i]) m[10*i +: 10] = 10'h3ff;
          chk($sformatf("f%0d_ack", frame_no), 64'(fire_ack), 64'(e.ack));
          chk($sformatf("f%0d_active", frame_no), 64'(bullet_active), 64'(e.act));
          chk($sformatf("f%0d_x", frame_no), 64'(bullet_x & m), 64'(e.x));
          chk($sformatf("f%0d_y", frame_no), 64'(bullet_y & m), 64'(e.y));
          chk($sformatf("f%0d_owner", frame_no), 64'(bullet_owner & e.act), 64'(e.own));
          chk($sformatf("f%0d_overrun", frame_no), 64'(frame_overrun), 64'(e.ovr));
          chk($sformatf("f%0d_busy_len", frame_no), 64'(busy_len), 64'(NS + 1));
        end
        busy_len  = 0;
        pulse_chk = 1'b1;
      end else if (fire_ack !== 2'b00) begin
        chk($sformatf("f%0d_ack_stray", frame_no), 64'(fire_ack), 64'd0);
      end
      if (busy === 1'b1) busy_len++;
      busy_prev = busy;
    end
  end

  // ---------------- stimulus ----------------
  task automatic check_zero(input string tag);
    chk({tag, "_active"},  64'(bullet_active), 64'd0);
    chk({tag, "_x"},       64'(bullet_x), 64'd0);
    chk({tag, "_y"},       64'(bullet_y), 64'd0);
    chk({tag, "_owner"},   64'(bullet_owner), 64'd0);
    chk({tag, "_ack"},     64'(fire_ack), 64'd0);
    chk({tag, "_busy"},    64'(busy), 64'd0);
    chk({tag, "_overrun"}, 64'(frame_overrun), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    mon_hold = 1'b1;
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_zero(tag);
    clear_exp();
    @(negedge clk);
    mon_hold = 1'b0;
  endtask

  task automatic shoot(input logic s1, input logic s2);
    @(negedge clk);
    shoot_1 = s1;
    shoot_2 = s2;
    @(negedge clk);
    shoot_1 = 1'b0;
    shoot_2 = 1'b0;
  endtask

  // mode 0: plain frame; 1: P1 shoot edge lands on the spawn edge;
  // 2: second tick during MOVE; 3: reset two cycles into MOVE
  task automatic frame(input int mode);
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    case (mode)
      1: begin
        repeat (4) @(negedge clk);
        shoot_1 = 1'b1;
        @(negedge clk) shoot_1 = 1'b0;
      end
      2: begin
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
      end
      3: begin
        mon_hold = 1'b1;
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        check_zero("abort");
        reset = 1'b0;
      end
      default: ;
    endcase
    repeat (8) @(negedge clk);
    if (mode == 3) mon_hold = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset("rst0");

    // single P1 shot, then one move
    p1x = 10'd100; p1y = 10'd200;
    shoot(1'b1, 1'b0);
    slot(0, 1, 0, 100, 200);                         push(2'b01, 0); frame(0);
    slot(0, 1, 0, 104, 200);                         push(2'b00, 0); frame(0);

    // P2 bullet near the left edge
    p2x = 10'd6; p2y = 10'd50;
    shoot(1'b0, 1'b1);
    slot(0, 1, 0, 108, 200); slot(1, 1, 1, 6, 50);   push(2'b10, 0); frame(0);
    slot(0, 1, 0, 112, 200); slot(1, 1, 1, 2, 50);   push(2'b00, 0); frame(0);
    slot(0, 1, 0, 116, 200); slot(1, 0, 1, 2, 50);   push(2'b00, 0); frame(0);

    do_reset("rst1");

    // both pending, all free
    p1x = 10'd300; p1y = 10'd10; p2x = 10'd400; p2y = 10'd20;
    shoot(1'b1, 1'b1);
    slot(0, 1, 0, 300, 10); slot(1, 1, 1, 400, 20);  push(2'b11, 0); frame(0);

    p1x = 10'd632; p1y = 10'd30;
    shoot(1'b1, 1'b0);
    slot(0, 1, 0, 304, 10); slot(1, 1, 1, 396, 20);
    slot(2, 1, 0, 632, 30);                          push(2'b01, 0); frame(0);

    // one free slot, both pending: P1 wins, pointer moves to P2
    p1x = 10'd10; p1y = 10'd40;
    shoot(1'b1, 1'b1);
    slot(0, 1, 0, 308, 10); slot(1, 1, 1, 392, 20);
    slot(2, 1, 0, 636, 30); slot(3, 1, 0, 10, 40);   push(2'b01, 0); frame(0);

    // slot2 leaves the right edge; P2 now has priority over a fresh P1 request
    shoot(1'b1, 1'b0);
    slot(0, 1, 0, 312, 10); slot(1, 1, 1, 388, 20);
    slot(2, 1, 1, 400, 20); slot(3, 1, 0, 14, 40);   push(2'b10, 0); frame(0);

    // full: P1 request waits, no ack
    slot(0, 1, 0, 316, 10); slot(1, 1, 1, 384, 20);
    slot(2, 1, 1, 396, 20); slot(3, 1, 0, 18, 40);   push(2'b00, 0); frame(0);

    do_reset("rst2");
    push(2'b00, 0); frame(0);

    // shoot edge on the grant cycle keeps the request alive
    p1x = 10'd50; p1y = 10'd60;
    shoot(1'b1, 1'b0);
    slot(0, 1, 0, 50, 60);                           push(2'b01, 0); frame(1);
    slot(0, 1, 0, 54, 60); slot(1, 1, 0, 50, 60);    push(2'b01, 0); frame(0);

    // tick while busy: flagged, sticky, frame unaffected
    slot(0, 1, 0, 58, 60); slot(1, 1, 0, 54, 60);    push(2'b00, 1); frame(2);
    slot(0, 1, 0, 62, 60); slot(1, 1, 0, 58, 60);    push(2'b00, 1); frame(0);

    // reset mid-MOVE with a P2 request pending: nothing granted afterwards
    p2x = 10'd200; p2y = 10'd300;
    shoot(1'b0, 1'b1);
    frame(3);
    clear_exp();
    push(2'b00, 0); frame(0);

    repeat (4) @(negedge clk);
    while (exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      chk("frame_missing", 64'd1, 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
